// File: rtl/data_mem_sb.sv
// Purpose: data-memory responder; combinational loads with forwarding from a posted-store buffer.
// Latency: loads 0 cycles; a buffered store reaches RAM on the next edge when mem_busy is low.
// Backpressure: stall refuses a store while the buffer is full; mem_busy holds the drain.
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

module data_mem_sb #(
  parameter int W         = `WORD_WIDTH,
  parameter int ADDR_BITS = 10,
  parameter int SB_DEPTH  = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_en,
  input  logic [W-1:0] l_addr,
  output logic [W-1:0] l_data,
  input  logic         store_en,
  input  logic [W-1:0] s_addr,
  input  logic [W-1:0] s_data,
  input  logic         mem_busy,
  output logic         stall,
  output logic         sb_empty,
  output logic         align_err
);

  localparam int PW        = $clog2(SB_DEPTH);
  localparam int CW        = PW + 1;
  localparam int RAM_WORDS = 1 << ADDR_BITS;

  typedef struct packed {
    logic [ADDR_BITS-1:0] idx;
    logic [W-1:0]         dat;
  } sb_entry_t;

  sb_entry_t            sb_mem [SB_DEPTH];
  logic [W-1:0]         ram    [RAM_WORDS];
  logic [PW-1:0]        head;
  logic [PW-1:0]        tail;
  logic [CW-1:0]        count;
  logic                 push;
  logic                 pop;
  logic [ADDR_BITS-1:0] l_idx;
  logic [ADDR_BITS-1:0] s_idx;
  sb_entry_t            head_ent;
  logic [PW-1:0]        fwd_pos;
  logic                 fwd_hit;
  logic [W-1:0]         fwd_dat;
  logic                 misalign;
  logic                 unused_addr_bits;

  // Upper address bits are ignored so high addresses alias onto the RAM.
  assign l_idx            = l_addr[ADDR_BITS+1:2];
  assign s_idx            = s_addr[ADDR_BITS+1:2];
  assign unused_addr_bits = ^{l_addr[W-1:ADDR_BITS+2], s_addr[W-1:ADDR_BITS+2]};

  // Full test uses the pre-edge count, so a same-cycle pop never lifts stall.
  assign stall    = store_en && (count == CW'(SB_DEPTH));
  assign push     = store_en && !stall;
  assign pop      = (count != '0) && !mem_busy;
  assign sb_empty = (count == '0);
  assign head_ent = sb_mem[head];
  assign misalign = (load_en && (l_addr[1:0] != 2'b00)) ||
                    (store_en && (s_addr[1:0] != 2'b00));

  // Load path: scan oldest to youngest so the youngest matching entry wins; head counts even while draining.
  always_comb begin
    fwd_pos = '0;
    fwd_hit = 1'b0;
    fwd_dat = '0;
    l_data  = '0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      fwd_pos = head + PW'(i);
      if ((CW'(i) < count) && (sb_mem[fwd_pos].idx == l_idx)) begin
        fwd_hit = 1'b1;
        fwd_dat = sb_mem[fwd_pos].dat;
      end
    end
    if (load_en) begin
      l_data = fwd_hit ? fwd_dat : ram[l_idx];
    end
  end

  // Buffer bookkeeping: pointers wrap naturally, count tracks occupancy; reset discards pending stores.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Buffer payload storage; contents are only meaningful within the live head..tail window.
  always_ff @(posedge clk) begin
    if (push) sb_mem[tail] <= {s_idx, s_data};
  end

  // Drain the head entry into RAM; RAM contents survive reset.
  always_ff @(posedge clk) begin
    if (pop) ram[head_ent.idx] <= head_ent.dat;
  end

  // Sticky misalignment flag, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           align_err <= 1'b0;
    else if (misalign) align_err <= 1'b1;
  end

endmodule

// File: tb/tb_data_mem_sb.sv
// Directed bench for data_mem_sb: store/load, forwarding, full-buffer stall, collisions, aliasing,
// misalignment and asynchronous reset. Inputs change 1 time unit after posedge; outputs are
// sampled a few units later, well away from the active edge.
module tb_data_mem_sb;
  localparam int W  = 32;
  localparam int AB = 10;
  localparam int D  = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         load_en;
  logic [W-1:0] l_addr;
  logic [W-1:0] l_data;
  logic         store_en;
  logic [W-1:0] s_addr;
  logic [W-1:0] s_data;
  logic         mem_busy;
  logic         stall;
  logic         sb_empty;
  logic         align_err;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  data_mem_sb #(.W(W), .ADDR_BITS(AB), .SB_DEPTH(D)) dut (
    .clk       (clk),
    .rst       (rst),
    .load_en   (load_en),
    .l_addr    (l_addr),
    .l_data    (l_data),
    .store_en  (store_en),
    .s_addr    (s_addr),
    .s_data    (s_data),
    .mem_busy  (mem_busy),
    .stall     (stall),
    .sb_empty  (sb_empty),
    .align_err (align_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ld_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    load_en = 1'b1;
    l_addr  = a;
    #1;
    chk(tag, l_data, exp);
    load_en = 1'b0;
  endtask

  task automatic put_store(input logic [31:0] a, input logic [31:0] d);
    store_en = 1'b1;
    s_addr   = a;
    s_data   = d;
  endtask

  // Occupancy must never exceed the buffer depth.
  always @(negedge clk) chk("cnt_bound", 32'(dut.count <= D), 32'd1);

  initial begin
    rst = 1'b1; load_en = 1'b0; store_en = 1'b1; mem_busy = 1'b0;
    l_addr = '0; s_addr = 32'h4; s_data = 32'h5;
    #2;
    chk("rst_sb_empty", 32'(sb_empty), 32'd1);
    chk("rst_align",    32'(align_err), 32'd0);
    chk("rst_stall",    32'(stall), 32'd0);
    chk("rst_ldata",    l_data, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; store_en = 1'b0;

    // Basic store then load
    put_store(32'h100, 32'hDEADBEEF);
    #1 chk("t1_stall", 32'(stall), 32'd0);
    step();
    store_en = 1'b0;
    chk("t1_not_empty", 32'(sb_empty), 32'd0);
    ld_chk("t1_fwd", 32'h100, 32'hDEADBEEF);
    step();
    chk("t1_empty", 32'(sb_empty), 32'd1);
    ld_chk("t1_ram_load", 32'h100, 32'hDEADBEEF);
    chk("t1_ram", dut.ram[32'h40], 32'hDEADBEEF);

    // Forwarding while the drain is blocked
    put_store(32'h40, 32'hAAAA0000);
    step();
    store_en = 1'b0;
    step();
    mem_busy = 1'b1;
    put_store(32'h40, 32'h11);
    step();
    put_store(32'h40, 32'h22);
    step();
    store_en = 1'b0;
    ld_chk("t2_fwd_young", 32'h40, 32'h22);
    chk("t2_ram_old", dut.ram[16], 32'hAAAA0000);
    l_addr = 32'h40;
    #1 chk("t2_noload_zero", l_data, 32'd0);
    mem_busy = 1'b0;
    step();
    chk("t2_ram_first", dut.ram[16], 32'h11);
    ld_chk("t2_fwd_after_pop", 32'h40, 32'h22);
    step();
    chk("t2_ram_second", dut.ram[16], 32'h22);
    chk("t2_empty", 32'(sb_empty), 32'd1);

    // Full buffer and stall release
    mem_busy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      put_store(32'h300 + 32'(4 * k), 32'h50 + 32'(k));
      #1 chk("t3_stall_fill", 32'(stall), 32'd0);
      step();
    end
    put_store(32'h310, 32'h54);
    #1 chk("t3_stall_full", 32'(stall), 32'd1);
    step();
    chk("t3_stall_held", 32'(stall), 32'd1);
    mem_busy = 1'b0;
    #1 chk("t3_stall_pop_cycle", 32'(stall), 32'd1);
    step();
    chk("t3_stall_clear", 32'(stall), 32'd0);
    step();
    store_en = 1'b0;
    repeat (4) step();
    for (int k = 0; k < 5; k++) begin
      chk("t3_ram_order", dut.ram[32'hC0 + k], 32'h50 + 32'(k));
    end
    chk("t3_empty", 32'(sb_empty), 32'd1);

    // Same-cycle load/store collision
    put_store(32'h200, 32'h1111);
    step();
    store_en = 1'b0;
    step();
    load_en = 1'b1; l_addr = 32'h200;
    put_store(32'h200, 32'h2222);
    #1 chk("t4_collide_old", l_data, 32'h1111);
    step();
    store_en = 1'b0;
    #1 chk("t4_collide_new", l_data, 32'h2222);
    load_en = 1'b0;
    step();

    // Upper address bits alias onto the same word
    put_store(32'h1000_0200, 32'h3333);
    step();
    store_en = 1'b0;
    step();
    ld_chk("t4_alias_load", 32'h200, 32'h3333);
    chk("t4_alias_ram", dut.ram[32'h80], 32'h3333);

    // Misaligned load
    chk("t5_flag_pre", 32'(align_err), 32'd0);
    load_en = 1'b1; l_addr = 32'h103;
    #1 chk("t5_misalign_data", l_data, 32'hDEADBEEF);
    step();
    load_en = 1'b0;
    chk("t5_flag_set", 32'(align_err), 32'd1);
    ld_chk("t5_aligned_load", 32'h100, 32'hDEADBEEF);
    step();
    chk("t5_flag_sticky", 32'(align_err), 32'd1);

    // Asynchronous reset with stores pending
    for (int k = 0; k < 3; k++) begin
      put_store(32'h500 + 32'(4 * k), 32'hA0 + 32'(k));
      step();
    end
    store_en = 1'b0;
    repeat (2) step();
    mem_busy = 1'b1;
    for (int k = 0; k < 3; k++) begin
      put_store(32'h500 + 32'(4 * k), 32'hB0 + 32'(k));
      step();
    end
    store_en = 1'b0;
    chk("t6_pending", 32'(sb_empty), 32'd0);
    #1 rst = 1'b1;
    #1;
    chk("t6_rst_empty", 32'(sb_empty), 32'd1);
    chk("t6_rst_align", 32'(align_err), 32'd0);
    step();
    rst = 1'b0;
    mem_busy = 1'b0;
    repeat (2) step();
    for (int k = 0; k < 3; k++) begin
      ld_chk("t6_ram_kept", 32'h500 + 32'(4 * k), 32'hA0 + 32'(k));
    end
    chk("t6_still_empty", 32'(sb_empty), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/data_mem_sb.md
Name: data_mem_sb

Overview:
- Data-memory responder for the single-cycle CPU's load/store port. Answers loads combinationally in the same cycle. Accepts stores into a small posted-store FIFO (store buffer) that drains into a word-addressed RAM, one entry per cycle.
- Loads forward from pending buffered stores, so the CPU always sees program-order memory.
- Provides a stall when the buffer is full, and a sticky alignment-error flag.

Parameters:
- W, `WORD_WIDTH (32): data and address width.
- ADDR_BITS, 10: RAM word-index width; RAM holds 2^ADDR_BITS words.
- SB_DEPTH, 4: store-buffer entries; must be a power of two, at least 2.

Ports:
- clk  input  1  clock; all state updates on posedge
- rst  input  1  asynchronous, active-high reset
- load_en  input  1  load request this cycle
- l_addr  input  W  load byte address
- l_data  output  W  load data, combinational
- store_en  input  1  store request this cycle
- s_addr  input  W  store byte address
- s_data  input  W  store data
- mem_busy  input  1  RAM write port unavailable this cycle; blocks drain
- stall  output  1  store refused this cycle; CPU must hold the store
- sb_empty  output  1  store buffer holds no entries
- align_err  output  1  sticky: a misaligned access was seen

Behaviour:
- Word index is addr[ADDR_BITS+1:2]. Address bits above this range are ignored, so upper addresses alias (wrap) onto the RAM.
- Reset (async, immediate):
  - Buffer count, head and tail pointers go to 0; sb_empty=1; align_err=0.
  - Pending stores are discarded, including on reset mid-stream.
  - RAM contents are not reset.
- stall = store_en && (count==SB_DEPTH), combinational. stall is 0 during reset.
- Push: on posedge, if store_en && !stall, append {index, s_data} at tail.
- Drain: on posedge, if count>0 && !mem_busy, write head entry to RAM[index] and pop it.
- Push and pop in the same edge: count unchanged. When full, a same-cycle pop does not lift stall; stall is based on count before the edge.
- Minimum latency: a store pushed at edge N reaches RAM at edge N+1 if mem_busy=0.
- l_data:
  - load_en=0: 0.
  - Otherwise, the data of the youngest buffer entry whose index matches.
  - If no entry matches, RAM[index].
  - The head entry being drained this cycle still counts as a match.
- A load and a store to the same address in the same cycle: the load returns the prior value. The new value is visible from the next cycle.
- Misalignment: if (load_en && l_addr[1:0]!=0) or (store_en && s_addr[1:0]!=0), align_err sets at the next edge. It stays set until reset. The access still proceeds on the aligned word.
- Count arithmetic: count is clog2(SB_DEPTH)+1 bits. Pointers are clog2(SB_DEPTH) bits and wrap naturally.
- Overflow and underflow are impossible by construction. The bench asserts count is never above SB_DEPTH.

Test Plan:
- Basic store/load: store 0x100←0xDEADBEEF, then idle 1 cycle → load 0x100 returns 0xDEADBEEF; sb_empty=1 after edge N+1.
- Forwarding under stall:
  - Hold mem_busy=1 and store 0x40←0x11 then 0x40←0x22 → load 0x40 returns 0x22 from the buffer.
  - RAM[0x10] is still old.
  - Release mem_busy → RAM gets 0x11 then 0x22 in two cycles.
- Full buffer: mem_busy=1, issue 5 back-to-back stores → stall=0 for the first 4, stall=1 on the 5th while it is held.
  - Drop mem_busy → stall clears the cycle after the first pop.
  - All 5 values land in order.
- Same-cycle collision and aliasing:
  - Load and store to 0x200 in one cycle → old value returned; next cycle returns the new value.
  - Store to 0x1000_0200 → load 0x200 returns the same data (with ADDR_BITS=10).
- Misalignment: load from 0x103 → align_err=1 after the edge; l_data equals the word at 0x100; flag persists through later aligned accesses.
- Reset mid-operation: mem_busy=1, 3 stores buffered, assert rst asynchronously → sb_empty=1 and align_err=0 immediately; RAM at those addresses is unchanged.
